// File: rtl/switch_debouncer_pkg.sv
// Shared defaults and width helper for the switch debouncer.
package switch_debouncer_pkg;

    localparam int DEB_WIDTH        = 8;
    localparam int DEB_TICK_DIV     = 1000;
    localparam int DEB_STABLE_TICKS = 20;

    // max(1, clog2(n)): a counter for 0..n-1 never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter, level and edge strobes.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int              CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Next edge commits s2 to level; the top registers the OR of these.
    assign accept = ena && tick && (s2 != level) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (!ena || s2 == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == LAST) begin
                    level <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH independent debouncers sharing one sample-tick prescaler.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH        = DEB_WIDTH,
    parameter int TICK_DIV     = DEB_TICK_DIV,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             any_change_o
);

    localparam int            PW     = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [WIDTH-1:0] accept;

    assign tick = ena && (pcnt == P_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt         <= '0;
            any_change_o <= 1'b0;
        end else begin
            if (!ena || pcnt == P_LAST) pcnt <= '0;
            else                        pcnt <= pcnt + PW'(1);
            any_change_o <= |accept;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .tick   (tick),
            .raw    (raw_i[i]),
            .level  (level_o[i]),
            .rise   (rise_o[i]),
            .fall   (fall_o[i]),
            .accept (accept[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench: instance A (TICK_DIV=1, STABLE_TICKS=3), instance B (TICK_DIV=4, STABLE_TICKS=2).
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, ena_a, ena_b;
    logic [7:0] raw_a, raw_b;
    logic [7:0] level_a, rise_a, fall_a, level_b, rise_b, fall_b;
    logic       any_a, any_b;
    logic [7:0] seen;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(3)) u_a (
        .clk(clk), .rst_n(rst_a), .ena(ena_a), .raw_i(raw_a),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .any_change_o(any_a)
    );

    switch_debouncer #(.WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(2)) u_b (
        .clk(clk), .rst_n(rst_b), .ena(ena_b), .raw_i(raw_b),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .any_change_o(any_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
        raw_a = 8'h00; raw_b = 8'h00;
        cyc(2);
        check("rst_level_a", level_a, 8'h00);
        check("rst_rise_a",  rise_a,  8'h00);
        check("rst_fall_a",  fall_a,  8'h00);
        check("rst_any_a",   {7'b0, any_a}, 8'h00);
        check("rst_level_b", level_b, 8'h00);

        // Prescaler: release with pcnt=0, ticks land on edges 3,7,11,... (0-based).
        rst_a = 1'b1; rst_b = 1'b1; ena_a = 1'b1; ena_b = 1'b1;
        raw_b = 8'h02;
        cyc(7);
        check("pre_level_edge6", level_b, 8'h00);
        cyc(1);
        check("pre_level_edge7", level_b, 8'h02);
        check("pre_rise_edge7",  rise_b,  8'h02);
        check("pre_any_edge7",   {7'b0, any_b}, 8'h01);
        // 3-cycle glitch low across the tick at edge 11: cnt only reaches 1.
        raw_b = 8'h00;
        cyc(3);
        raw_b = 8'h02;
        seen = 8'h00;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seen = seen | fall_b | rise_b;
        end
        check("pre_glitch_level", level_b, 8'h02);
        check("pre_glitch_strobe", seen, 8'h00);
        check("idle_level_a", level_a, 8'h00);

        // Basic press on instance A.
        raw_a = 8'h01;
        cyc(4);
        check("press_level_c4", level_a, 8'h00);
        cyc(1);
        check("press_level_c5", level_a, 8'h01);
        check("press_rise_c5",  rise_a,  8'h01);
        check("press_fall_c5",  fall_a,  8'h00);
        check("press_any_c5",   {7'b0, any_a}, 8'h01);
        cyc(1);
        check("press_rise_c6",  rise_a,  8'h00);
        check("press_any_c6",   {7'b0, any_a}, 8'h00);

        // Bounce on bit 3: 1,0,1,0 for 2 cycles each, then held high.
        seen = 8'h00;
        for (int p = 0; p < 4; p++) begin
            raw_a[3] = (p % 2 == 0);
            repeat (2) begin
                cyc(1);
                seen = seen | rise_a | fall_a | {7'b0, any_a};
            end
        end
        raw_a[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            seen = seen | rise_a | fall_a | {7'b0, any_a};
        end
        check("bounce_no_strobe", seen, 8'h00);
        check("bounce_level_c4", level_a, 8'h01);
        cyc(1);
        check("bounce_level_c5", level_a, 8'h09);
        check("bounce_rise_c5",  rise_a,  8'h08);

        // Release and multi-bit.
        raw_a = 8'hFF;
        cyc(6);
        check("all_high_level", level_a, 8'hFF);
        raw_a = 8'h0A;
        cyc(4);
        check("rel_level_c4", level_a, 8'hFF);
        cyc(1);
        check("rel_level_c5", level_a, 8'h0A);
        check("rel_fall_c5",  fall_a,  8'hF5);
        check("rel_rise_c5",  rise_a,  8'h00);
        check("rel_any_c5",   {7'b0, any_a}, 8'h01);
        cyc(1);
        check("rel_fall_c6",  fall_a,  8'h00);

        // Enable freeze with bit 0 mid-qualification (cnt=1).
        raw_a = 8'h0B;
        cyc(3);
        ena_a = 1'b0;
        seen = 8'h00;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen = seen | rise_a | fall_a | {7'b0, any_a};
        end
        check("frz_level", level_a, 8'h0A);
        check("frz_strobe", seen, 8'h00);
        ena_a = 1'b1;
        cyc(2);
        check("frz_resume_c2", level_a, 8'h0A);
        cyc(1);
        check("frz_resume_c3", level_a, 8'h0B);
        check("frz_rise_c3",   rise_a,  8'h01);

        // Async reset between edges, then re-qualify the held input.
        raw_a = 8'h0A;
        cyc(6);
        check("pre_rst_level", level_a, 8'h0A);
        #3;
        rst_a = 1'b0;
        #1;
        check("arst_level", level_a, 8'h00);
        check("arst_rise",  rise_a,  8'h00);
        check("arst_fall",  fall_a,  8'h00);
        check("arst_any",   {7'b0, any_a}, 8'h00);
        cyc(1);
        rst_a = 1'b1;
        cyc(4);
        check("rq_level_c4", level_a, 8'h00);
        cyc(1);
        check("rq_level_c5", level_a, 8'h0A);
        check("rq_rise_c5",  rise_a,  8'h0A);
        check("rq_any_c5",   {7'b0, any_a}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
